// File: rtl/prim_skidfifo.sv
// prim_skidfifo: DEPTH-entry first-word-fall-through elastic buffer.
// Upstream ready is registered-only (plus flush); downstream valid is masked
// by stall and flush. Flush and reset clear pointers and count, not storage.
module prim_skidfifo #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEPTH           = 4,
  parameter bit          ZERO_ON_INVALID = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       dstall_i,
  input  logic                       uvld_i,
  input  logic [WIDTH-1:0]           udat_i,
  output logic                       urdy_o,
  input  logic                       drdy_i,
  output logic                       dvld_o,
  output logic [WIDTH-1:0]           ddat_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, ubeat, dbeat;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign urdy_o  = !full && !flush_i;
  assign dvld_o  = !empty && !dstall_i && !flush_i;
  assign ubeat   = uvld_i && urdy_o;
  assign dbeat   = dvld_o && drdy_i;
  assign count_o = count_q;

  // Next-state for pointers and occupancy; flush overrides any beat.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (ubeat) wr_ptr_d = wr_ptr_q + AW'(1);
      if (dbeat) rd_ptr_d = rd_ptr_q + AW'(1);
      if (ubeat && !dbeat)      count_d = count_q + CW'(1);
      else if (dbeat && !ubeat) count_d = count_q - CW'(1);
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array: written on accepted upstream beats, never reset.
  always_ff @(posedge clk) begin
    if (ubeat) mem_q[wr_ptr_q] <= udat_i;
  end

  // Head-of-queue output, optionally zeroed while not valid.
  always_comb begin
    ddat_o = mem_q[rd_ptr_q];
    if (ZERO_ON_INVALID && !dvld_o) ddat_o = '0;
  end

endmodule

// File: tb/tb_prim_skidfifo.sv
// Directed bench for prim_skidfifo (WIDTH=32, DEPTH=4, ZERO_ON_INVALID=1).
module tb_prim_skidfifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i, dstall_i, uvld_i, drdy_i;
  logic [31:0] udat_i;
  logic        urdy_o, dvld_o;
  logic [31:0] ddat_o;
  logic [2:0]  count_o;

  int n_checks = 0;
  int n_fail   = 0;

  prim_skidfifo #(.WIDTH(32), .DEPTH(4), .ZERO_ON_INVALID(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush_i),
    .dstall_i (dstall_i),
    .uvld_i   (uvld_i),
    .udat_i   (udat_i),
    .urdy_o   (urdy_o),
    .drdy_i   (drdy_i),
    .dvld_o   (dvld_o),
    .ddat_o   (ddat_o),
    .count_o  (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush, dstall, uvld;
    logic [31:0] udat;
    logic        drdy;
    logic        urdy, dvld;
    logic [31:0] ddat;
    logic [2:0]  count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic fl, logic st, logic uv, logic [31:0] ud, logic dr,
                             logic ur, logic dv, logic [31:0] dd, logic [2:0] cn);
    vec_t r;
    r.flush = fl; r.dstall = st; r.uvld = uv; r.udat = ud; r.drdy = dr;
    r.urdy = ur; r.dvld = dv; r.ddat = dd; r.count = cn;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    flush_i = 1'b0; dstall_i = 1'b0; uvld_i = 1'b0; udat_i = '0; drdy_i = 1'b0;
  endtask

  logic [31:0] q[$];
  logic [31:0] d;
  logic        exp_urdy, exp_dvld;
  int          guard;

  initial begin
    reset = 1'b0;
    idle_inputs();

    // ------------------------------------------------------------ reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_dvld",  32'(dvld_o),  0);
    chk("rst_urdy",  32'(urdy_o),  1);
    chk("rst_ddat",  ddat_o,       0);
    reset = 1'b1;
    @(posedge clk); #1;

    // -------------------------------------------------------- vector table
    //            fl st uv udat    dr   ur dv ddat   cnt
    // in-order pass-through
    vecs.push_back(v(0, 0, 1, 32'hA1, 1,  1, 0, 32'h00, 0));
    vecs.push_back(v(0, 0, 1, 32'hB2, 1,  1, 1, 32'hA1, 1));
    vecs.push_back(v(0, 0, 1, 32'hC3, 1,  1, 1, 32'hB2, 1));
    vecs.push_back(v(0, 0, 0, 32'h00, 1,  1, 1, 32'hC3, 1));
    vecs.push_back(v(0, 0, 0, 32'h00, 0,  1, 0, 32'h00, 0));
    // fill to full, no full-bypass, one pop, refill
    vecs.push_back(v(0, 0, 1, 32'h10, 0,  1, 0, 32'h00, 0));
    vecs.push_back(v(0, 0, 1, 32'h11, 0,  1, 1, 32'h10, 1));
    vecs.push_back(v(0, 0, 1, 32'h12, 0,  1, 1, 32'h10, 2));
    vecs.push_back(v(0, 0, 1, 32'h13, 0,  1, 1, 32'h10, 3));
    vecs.push_back(v(0, 0, 1, 32'h14, 0,  0, 1, 32'h10, 4));
    vecs.push_back(v(0, 0, 1, 32'h14, 1,  0, 1, 32'h10, 4));
    vecs.push_back(v(0, 0, 1, 32'h14, 0,  1, 1, 32'h11, 3));
    vecs.push_back(v(0, 0, 1, 32'h15, 1,  0, 1, 32'h11, 4));
    vecs.push_back(v(0, 0, 0, 32'h00, 1,  1, 1, 32'h12, 3));
    vecs.push_back(v(0, 0, 0, 32'h00, 1,  1, 1, 32'h13, 2));
    vecs.push_back(v(0, 0, 0, 32'h00, 1,  1, 1, 32'h14, 1));
    vecs.push_back(v(0, 0, 0, 32'h00, 1,  1, 0, 32'h00, 0));
    // stall with drdy high
    vecs.push_back(v(0, 0, 1, 32'h55, 0,  1, 0, 32'h00, 0));
    vecs.push_back(v(0, 0, 1, 32'h66, 0,  1, 1, 32'h55, 1));
    for (int unsigned i = 0; i < 5; i++)
      vecs.push_back(v(0, 1, 0, 32'h00, 1,  1, 0, 32'h00, 2));
    vecs.push_back(v(0, 0, 0, 32'h00, 1,  1, 1, 32'h55, 2));
    vecs.push_back(v(0, 0, 0, 32'h00, 1,  1, 1, 32'h66, 1));
    vecs.push_back(v(0, 0, 0, 32'h00, 0,  1, 0, 32'h00, 0));
    // flush with an offered beat
    vecs.push_back(v(0, 0, 1, 32'h01, 0,  1, 0, 32'h00, 0));
    vecs.push_back(v(0, 0, 1, 32'h02, 0,  1, 1, 32'h01, 1));
    vecs.push_back(v(0, 0, 1, 32'h03, 0,  1, 1, 32'h01, 2));
    vecs.push_back(v(1, 0, 1, 32'h77, 1,  0, 0, 32'h00, 3));
    vecs.push_back(v(0, 0, 1, 32'h88, 0,  1, 0, 32'h00, 0));
    vecs.push_back(v(0, 0, 0, 32'h00, 1,  1, 1, 32'h88, 1));
    vecs.push_back(v(0, 0, 0, 32'h00, 0,  1, 0, 32'h00, 0));
    // concurrent push/pop at DEPTH-1 keeps urdy high
    vecs.push_back(v(0, 0, 1, 32'h21, 0,  1, 0, 32'h00, 0));
    vecs.push_back(v(0, 0, 1, 32'h22, 0,  1, 1, 32'h21, 1));
    vecs.push_back(v(0, 0, 1, 32'h23, 0,  1, 1, 32'h21, 2));
    vecs.push_back(v(0, 0, 1, 32'h24, 1,  1, 1, 32'h21, 3));
    vecs.push_back(v(0, 0, 0, 32'h00, 0,  1, 1, 32'h22, 3));
    vecs.push_back(v(0, 0, 0, 32'h00, 1,  1, 1, 32'h22, 3));
    vecs.push_back(v(0, 0, 0, 32'h00, 1,  1, 1, 32'h23, 2));
    vecs.push_back(v(0, 0, 0, 32'h00, 1,  1, 1, 32'h24, 1));
    vecs.push_back(v(0, 0, 0, 32'h00, 0,  1, 0, 32'h00, 0));

    foreach (vecs[i]) begin
      flush_i  = vecs[i].flush;
      dstall_i = vecs[i].dstall;
      uvld_i   = vecs[i].uvld;
      udat_i   = vecs[i].udat;
      drdy_i   = vecs[i].drdy;
      @(negedge clk);
      chk($sformatf("v%0d_urdy", i),  32'(urdy_o),  32'(vecs[i].urdy));
      chk($sformatf("v%0d_dvld", i),  32'(dvld_o),  32'(vecs[i].dvld));
      chk($sformatf("v%0d_ddat", i),  ddat_o,       vecs[i].ddat);
      chk($sformatf("v%0d_count", i), 32'(count_o), 32'(vecs[i].count));
      @(posedge clk); #1;
    end
    idle_inputs();

    // ---------------------------------- streaming with scoreboard, wraparound
    q.delete();
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      uvld_i = 1'b1; udat_i = d; drdy_i = 1'b1;
      @(negedge clk);
      exp_urdy = (q.size() != 4);
      exp_dvld = (q.size() != 0);
      chk("stream_urdy",  32'(urdy_o),  32'(exp_urdy));
      chk("stream_dvld",  32'(dvld_o),  32'(exp_dvld));
      chk("stream_count", 32'(count_o), 32'(q.size()));
      if (exp_dvld) chk("stream_ddat", ddat_o, q.pop_front());
      if (exp_urdy) q.push_back(d);
      @(posedge clk); #1;
    end
    uvld_i = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      @(negedge clk);
      chk("drain_dvld", 32'(dvld_o), 1);
      if (dvld_o) chk("drain_ddat", ddat_o, q.pop_front());
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_left", 32'(q.size()), 0);
    @(negedge clk);
    chk("drain_count", 32'(count_o), 0);
    @(posedge clk); #1;
    idle_inputs();

    // ------------------------------------------ asynchronous mid-cycle reset
    for (int i = 0; i < 3; i++) begin
      uvld_i = 1'b1; udat_i = 32'hE0 + 32'(i);
      @(posedge clk); #1;
    end
    uvld_i = 1'b0;
    chk("pre_rst_count", 32'(count_o), 3);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", 32'(count_o), 0);
    chk("arst_dvld",  32'(dvld_o),  0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_urdy",  32'(urdy_o),  1);
    chk("post_rst_count", 32'(count_o), 0);
    chk("post_rst_dvld",  32'(dvld_o),  0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
